// File: rtl/float_sqrt_prep.sv
// rtl/float_sqrt_prep.sv - sqrt operand preparation: delayed capture, special classification, normalisation.
// Four register stages: capture/decode, normalise, halve/align, output hold.
module float_sqrt_prep #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] delay0,
    output logic              valid_out,
    output logic              special_out,
    output logic [31:0]       special_val,
    output logic              invalid_out,
    output logic [7:0]        exp_out,
    output logic [24:0]       mant_out
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              sample;

    // stage 1: captured operand and class flags
    logic        s1_v_q, s1_sign_q, s1_zero_q, s1_den_q, s1_inf_q, s1_nan_q;
    logic [7:0]  s1_exp_q;
    logic [22:0] s1_frac_q;

    // stage 2: normalised significand, unbiased exponent, special result
    logic               s2_v_q, s2_spec_q, s2_inv_q;
    logic [23:0]        s2_sig_q;
    logic signed [9:0]  s2_e_q;
    logic [31:0]        s2_val_q;

    // stage 3: radicand and halved exponent
    logic        s3_v_q, s3_spec_q, s3_inv_q;
    logic [31:0] s3_val_q;
    logic [7:0]  s3_exp_q;
    logic [24:0] s3_mant_q;

    logic        out_v_q, out_spec_q, out_inv_q;
    logic [31:0] out_val_q;
    logic [7:0]  out_exp_q;
    logic [24:0] out_mant_q;

    // A sample and a fresh run in the same cycle both take effect.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        sample  = armed_q && (cnt_q == '0);
        if (armed_q) begin
            if (cnt_q == '0) armed_d = 1'b0;
            else             cnt_d   = cnt_q - DATA_W'(1);
        end
        if (run) begin
            cnt_d   = delay0;
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_den_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_exp_q  <= '0;
            s1_frac_q <= '0;
        end else begin
            s1_v_q <= sample;
            if (sample) begin
                s1_sign_q <= in0[31];
                s1_exp_q  <= in0[30:23];
                s1_frac_q <= in0[22:0];
                s1_zero_q <= (in0[30:23] == 8'd0)   && (in0[22:0] == '0);
                s1_den_q  <= (in0[30:23] == 8'd0)   && (in0[22:0] != '0);
                s1_inf_q  <= (in0[30:23] == 8'd255) && (in0[22:0] == '0);
                s1_nan_q  <= (in0[30:23] == 8'd255) && (in0[22:0] != '0);
            end
        end
    end

    logic [4:0]        lod_k;
    logic [23:0]       sig_d;
    logic signed [9:0] e_d;
    logic              spec_d, inv_d;
    logic [31:0]       val_d;

    always_comb begin
        lod_k = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (s1_frac_q[i]) lod_k = 5'(i);
        end
        if (s1_den_q) begin
            sig_d = 24'(s1_frac_q) << (5'd23 - lod_k);
            e_d   = $signed({5'd0, lod_k}) - 10'sd149;
        end else begin
            sig_d = {1'b1, s1_frac_q};
            e_d   = $signed({2'd0, s1_exp_q}) - 10'sd127;
        end
        spec_d = s1_nan_q || s1_zero_q || s1_inf_q || s1_sign_q;
        inv_d  = 1'b0;
        val_d  = '0;
        if (s1_nan_q) begin
            val_d = QNAN;
            inv_d = 1'b1;
        end else if (s1_zero_q) begin
            val_d = {s1_sign_q, 31'd0};
        end else if (s1_sign_q) begin
            val_d = QNAN;
            inv_d = 1'b1;
        end else if (s1_inf_q) begin
            val_d = PINF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            s2_spec_q <= 1'b0;
            s2_inv_q  <= 1'b0;
            s2_sig_q  <= '0;
            s2_e_q    <= '0;
            s2_val_q  <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_spec_q <= spec_d;
                s2_inv_q  <= inv_d;
                s2_sig_q  <= sig_d;
                s2_e_q    <= e_d;
                s2_val_q  <= val_d;
            end
        end
    end

    // Arithmetic shift gives floor(e/2) for both parities.
    logic signed [9:0] half_e;
    logic signed [9:0] bexp;
    assign half_e = s2_e_q >>> 1;
    assign bexp   = half_e + 10'sd127;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v_q    <= 1'b0;
            s3_spec_q <= 1'b0;
            s3_inv_q  <= 1'b0;
            s3_val_q  <= '0;
            s3_exp_q  <= '0;
            s3_mant_q <= '0;
        end else begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_spec_q <= s2_spec_q;
                s3_inv_q  <= s2_inv_q;
                s3_val_q  <= s2_val_q;
                if (s2_spec_q) begin
                    s3_exp_q  <= '0;
                    s3_mant_q <= '0;
                end else begin
                    s3_exp_q  <= bexp[7:0];
                    s3_mant_q <= s2_e_q[0] ? {s2_sig_q, 1'b0} : {1'b0, s2_sig_q};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v_q    <= 1'b0;
            out_spec_q <= 1'b0;
            out_inv_q  <= 1'b0;
            out_val_q  <= '0;
            out_exp_q  <= '0;
            out_mant_q <= '0;
        end else begin
            out_v_q <= s3_v_q;
            if (s3_v_q) begin
                out_spec_q <= s3_spec_q;
                out_inv_q  <= s3_inv_q;
                out_val_q  <= s3_val_q;
                out_exp_q  <= s3_exp_q;
                out_mant_q <= s3_mant_q;
            end
        end
    end

    assign valid_out   = out_v_q;
    assign special_out = out_spec_q;
    assign invalid_out = out_inv_q;
    assign special_val = out_val_q;
    assign exp_out     = out_exp_q;
    assign mant_out    = out_mant_q;

endmodule

// File: tb/tb_float_sqrt_prep.sv
// tb/tb_float_sqrt_prep.sv - self-checking bench for float_sqrt_prep against a value-level model.
module tb_float_sqrt_prep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] in0 = '0;
    logic [31:0] delay0 = '0;
    wire         valid_out, special_out, invalid_out;
    wire  [31:0] special_val;
    wire  [7:0]  exp_out;
    wire  [24:0] mant_out;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        special;
        logic [31:0] val;
        logic        inv;
        logic [7:0]  exp;
        logic [24:0] mant;
    } res_t;

    float_sqrt_prep #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .in0(in0), .delay0(delay0),
        .valid_out(valid_out), .special_out(special_out), .special_val(special_val),
        .invalid_out(invalid_out), .exp_out(exp_out), .mant_out(mant_out)
    );

    always #5 clk = ~clk;

    // value = m * 2^(e-23); scale m into [2^23, 2^24), then make e even by doubling m
    function automatic res_t model(input logic [31:0] x);
        res_t r;
        int   ef, f, m, e;
        r  = '0;
        ef = int'(x[30:23]);
        f  = int'(x[22:0]);
        if (ef == 255 && f != 0) begin
            r.special = 1'b1; r.val = 32'h7FC00000; r.inv = 1'b1;
        end else if (ef == 0 && f == 0) begin
            r.special = 1'b1; r.val = x;
        end else if (x[31]) begin
            r.special = 1'b1; r.val = 32'h7FC00000; r.inv = 1'b1;
        end else if (ef == 255) begin
            r.special = 1'b1; r.val = 32'h7F800000;
        end else begin
            if (ef == 0) begin m = f; e = -126; end
            else begin m = f + (1 << 23); e = ef - 127; end
            while (m < (1 << 23)) begin m = m * 2; e = e - 1; end
            if (e % 2 != 0) begin m = m * 2; e = e - 1; end
            r.exp  = 8'(e / 2 + 127);
            r.mant = 25'(m);
        end
        return r;
    endfunction

    function automatic res_t grab();
        return {special_out, special_val, invalid_out, exp_out, mant_out};
    endfunction

    // One isolated operation; lat counts edges after the run edge, -1 when no pulse arrives.
    task automatic do_op(input logic [31:0] x, input int d, output res_t r,
                         output int lat, output logic stayed);
        @(negedge clk);
        in0 = x; delay0 = 32'(d); run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        lat = -1;
        r = '0;
        stayed = 1'b0;
        for (int i = 1; i <= d + 12; i++) begin
            @(posedge clk); #1;
            if (i == d + 1) in0 = $urandom;
            if (valid_out) begin
                lat = i;
                r = grab();
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            stayed = valid_out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (valid_out !== 1'b0)   begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        tests++; if (special_out !== 1'b0) begin fails++; $display("FAIL reset_special got=%b exp=0", special_out); end
        tests++; if (invalid_out !== 1'b0) begin fails++; $display("FAIL reset_invalid got=%b exp=0", invalid_out); end
        tests++; if (special_val !== 32'h0) begin fails++; $display("FAIL reset_val got=%h exp=0", special_val); end
        tests++; if (exp_out !== 8'h0)     begin fails++; $display("FAIL reset_exp got=%h exp=0", exp_out); end
        tests++; if (mant_out !== 25'h0)   begin fails++; $display("FAIL reset_mant got=%h exp=0", mant_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] xs [9];
        res_t        ex [9];
        res_t        r;
        int          lat;
        logic        stayed;
        xs[0] = 32'h40800000; ex[0] = {1'b0, 32'h0, 1'b0, 8'h80, 25'h0800000};
        xs[1] = 32'h40000000; ex[1] = {1'b0, 32'h0, 1'b0, 8'h7F, 25'h1000000};
        xs[2] = 32'h3F000000; ex[2] = {1'b0, 32'h0, 1'b0, 8'h7E, 25'h1000000};
        xs[3] = 32'h00000001; ex[3] = {1'b0, 32'h0, 1'b0, 8'h34, 25'h1000000};
        xs[4] = 32'h00400000; ex[4] = {1'b0, 32'h0, 1'b0, 8'h3F, 25'h1000000};
        xs[5] = 32'hBF800000; ex[5] = {1'b1, 32'h7FC00000, 1'b1, 8'h0, 25'h0};
        xs[6] = 32'h80000000; ex[6] = {1'b1, 32'h80000000, 1'b0, 8'h0, 25'h0};
        xs[7] = 32'h7F800000; ex[7] = {1'b1, 32'h7F800000, 1'b0, 8'h0, 25'h0};
        xs[8] = 32'h7FA00001; ex[8] = {1'b1, 32'h7FC00000, 1'b1, 8'h0, 25'h0};
        for (int j = 0; j < 9; j++) begin
            do_op(xs[j], 0, r, lat, stayed);
            tests++; if (lat !== 4) begin fails++; $display("FAIL dir_latency x=%h got=%0d exp=4", xs[j], lat); end
            tests++; if (r !== ex[j]) begin fails++; $display("FAIL dir_result x=%h got=%h exp=%h", xs[j], r, ex[j]); end
            tests++; if (stayed !== 1'b0) begin fails++; $display("FAIL dir_pulse_width x=%h got=%b exp=0", xs[j], stayed); end
        end
    endtask

    task automatic test_delay();
        int   pulses = 0;
        int   pedge = -1;
        res_t r = '0;
        res_t ex;
        ex = model(32'h41100000);
        @(negedge clk);
        in0 = 32'h41100000; delay0 = 32'd5; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        run = 1'b1; delay0 = 32'd2;
        @(posedge clk); #1;
        run = 1'b0;
        for (int e = 4; e <= 16; e++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                pulses++;
                if (pedge < 0) begin pedge = e; r = grab(); end
            end
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL delay_pulses got=%0d exp=1", pulses); end
        tests++; if (pedge !== 9) begin fails++; $display("FAIL delay_edge got=%0d exp=9", pedge); end
        tests++; if (r !== ex) begin fails++; $display("FAIL delay_result got=%h exp=%h", r, ex); end
    endtask

    task automatic test_reset_mid();
        int   pulses = 0;
        res_t r;
        int   lat;
        logic stayed;
        @(negedge clk);
        in0 = 32'h40800000; delay0 = 32'd0; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (grab() !== res_t'(0)) begin fails++; $display("FAIL midreset_outputs got=%h exp=0", grab()); end
        repeat (3) begin
            @(posedge clk); #1;
            if (valid_out) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_out) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
        do_op(32'h40800000, 0, r, lat, stayed);
        tests++; if (lat !== 4) begin fails++; $display("FAIL postreset_latency got=%0d exp=4", lat); end
        tests++; if (r !== model(32'h40800000)) begin fails++; $display("FAIL postreset_result got=%h exp=%h", r, model(32'h40800000)); end
    endtask

    task automatic test_random();
        logic [31:0] x;
        res_t        r;
        int          lat, d;
        logic        stayed;
        for (int j = 0; j < 24; j++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0: x[30:23] = 8'($urandom_range(1, 254));
                1: begin x[30:23] = 8'd0; if (x[22:0] == 23'd0) x[0] = 1'b1; end
                2: x[30:0] = 31'd0;
                3: begin x[30:23] = 8'd255; x[22:0] = 23'd0; end
                4: begin x[30:23] = 8'd255; if (x[22:0] == 23'd0) x[5] = 1'b1; end
                default: ;
            endcase
            d = $urandom_range(0, 6);
            do_op(x, d, r, lat, stayed);
            tests++; if (lat !== d + 4) begin fails++; $display("FAIL rand_latency x=%h d=%0d got=%0d exp=%0d", x, d, lat, d + 4); end
            tests++; if (r !== model(x)) begin fails++; $display("FAIL rand_result x=%h got=%h exp=%h", x, r, model(x)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [8];
        res_t        got[$];
        int          at[$];
        for (int j = 0; j < 8; j++) begin
            xs[j] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        @(negedge clk);
        in0 = xs[0]; delay0 = 32'd0; run = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                got.push_back(grab());
                at.push_back(e);
            end
            if (e < 8) in0 = xs[e];
            if (e == 7) run = 1'b0;
        end
        tests++; if (got.size() !== 8) begin fails++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
        for (int j = 0; j < got.size() && j < 8; j++) begin
            tests++; if (at[j] !== 4 + j) begin fails++; $display("FAIL b2b_edge idx=%0d got=%0d exp=%0d", j, at[j], 4 + j); end
            tests++; if (got[j] !== model(xs[j])) begin fails++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", j, got[j], model(xs[j])); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_delay();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
